// File: rtl/m_cache_refill_pkg.sv
// Shared definitions for the instruction-cache family (refill engine and cache arrays).
package m_cache_refill_pkg;

    localparam int IDX_W  = 5;
    localparam int TAG_W  = 25;
    localparam int DATA_W = 32;
    localparam int FILL_W = 58;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_ERR  = 2'd3
    } refill_state_t;

    // Cache line entry as stored in the arrays: {valid, tag, data}.
    function automatic logic [FILL_W-1:0] pack_fill(input logic [TAG_W-1:0]  tag,
                                                    input logic [DATA_W-1:0] data);
        return {1'b1, tag, data};
    endfunction

endpackage

// File: rtl/m_cache_refill.sv
// Instruction-cache refill engine: on a miss, fetch one word from memory and
// write it into the cache as a valid entry; abort with an error pulse if memory
// does not answer within TIMEOUT request cycles. Way choice belongs to the cache.
module m_cache_refill
    import m_cache_refill_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                w_clk,
    input  logic                w_rst_n,
    input  logic                w_miss_req,
    input  logic [31:0]         w_miss_adr,
    output logic                w_busy,
    output logic                w_mem_req,
    output logic [31:0]         w_mem_adr,
    input  logic                w_mem_ack,
    input  logic [DATA_W-1:0]   w_mem_rdata,
    output logic                w_we,
    output logic [IDX_W-1:0]    w_wadr,
    output logic [FILL_W-1:0]   w_wd,
    output logic                w_done,
    output logic                w_err,
    output logic [31:0]         w_fill_cnt
);

    // Wait counter is at least 8 bits, wider only if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    refill_state_t       r_state;
    logic [31:0]         r_adr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_mem_req;
    logic                r_we;
    logic                r_done;
    logic                r_err;
    logic [IDX_W-1:0]    r_wadr;
    logic [FILL_W-1:0]   r_wd;
    logic [31:0]         r_fill_cnt;

    // Refill FSM; every output is registered and set on the edge entering its state.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_adr      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wadr     <= '0;
            r_wd       <= '0;
            r_fill_cnt <= '0;
        end else begin
            // single-cycle strobes and the fill bus default low
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_wadr <= '0;
            r_wd   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_miss_req) begin
                        r_adr     <= {w_miss_adr[31:2], 2'b00};
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_mem_req <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // ack beats timeout when both land in the same cycle
                    if (w_mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_adr      <= '0;
                        r_we       <= 1'b1;
                        r_done     <= 1'b1;
                        r_wadr     <= r_adr[6:2];
                        r_wd       <= pack_fill(r_adr[31:7], w_mem_rdata);
                        r_fill_cnt <= r_fill_cnt + 32'd1;
                        r_state    <= ST_FILL;
                    end else if (r_cnt == LAST_WAIT) begin
                        r_mem_req <= 1'b0;
                        r_adr     <= '0;
                        r_err     <= 1'b1;
                        r_state   <= ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FILL, ST_ERR: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_busy     = r_busy;
    assign w_mem_req  = r_mem_req;
    assign w_mem_adr  = r_adr;
    assign w_we       = r_we;
    assign w_wadr     = r_wadr;
    assign w_wd       = r_wd;
    assign w_done     = r_done;
    assign w_err      = r_err;
    assign w_fill_cnt = r_fill_cnt;

endmodule

// File: tb/tb_m_cache_refill.sv
// Randomized scoreboard bench for m_cache_refill.
module tb_m_cache_refill;

    localparam int TO = 12;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        w_miss_req = 1'b0;
    logic [31:0] w_miss_adr = '0;
    logic        w_busy;
    logic        w_mem_req;
    logic [31:0] w_mem_adr;
    logic        w_mem_ack = 1'b0;
    logic [31:0] w_mem_rdata = '0;
    logic        w_we;
    logic [4:0]  w_wadr;
    logic [57:0] w_wd;
    logic        w_done;
    logic        w_err;
    logic [31:0] w_fill_cnt;

    m_cache_refill #(.TIMEOUT(TO)) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_miss_req  (w_miss_req),
        .w_miss_adr  (w_miss_adr),
        .w_busy      (w_busy),
        .w_mem_req   (w_mem_req),
        .w_mem_adr   (w_mem_adr),
        .w_mem_ack   (w_mem_ack),
        .w_mem_rdata (w_mem_rdata),
        .w_we        (w_we),
        .w_wadr      (w_wadr),
        .w_wd        (w_wd),
        .w_done      (w_done),
        .w_err       (w_err),
        .w_fill_cnt  (w_fill_cnt)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        bit          is_err;
        logic [4:0]  wadr;
        logic [57:0] wd;
        logic [31:0] cnt;
        int          req_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = '0;
    logic [31:0] exp_adr = '0;
    int          req_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a miss with ack after d silent REQ cycles fills when d < TO,
    // otherwise the refill times out after exactly TO REQ cycles.
    task automatic run_txn(input logic [31:0] adr, input int d, input logic [31:0] data);
        exp_t e;
        @(negedge w_clk);
        w_miss_req = 1'b1;
        w_miss_adr = adr;
        w_mem_ack  = 1'b0;
        exp_adr    = {adr[31:2], 2'b00};
        if (d < TO) begin
            model_cnt = model_cnt + 32'd1;
            e.is_err  = 1'b0;
            e.wadr    = adr[6:2];
            e.wd      = {1'b1, adr[31:7], data};
            e.cnt     = model_cnt;
            e.req_cyc = d + 1;
        end else begin
            e.is_err  = 1'b1;
            e.wadr    = '0;
            e.wd      = '0;
            e.cnt     = model_cnt;
            e.req_cyc = TO;
        end
        sb.push_back(e);
        @(negedge w_clk);
        for (int i = 0; i < e.req_cyc; i++) begin
            // extra misses while busy must be ignored
            w_miss_req  = 1'($urandom_range(0, 1));
            w_miss_adr  = $urandom;
            w_mem_ack   = (i == d);
            w_mem_rdata = (i == d) ? data : $urandom;
            @(negedge w_clk);
        end
        // FILL/ERR cycle: misses and acks ignored
        w_miss_req  = 1'($urandom_range(0, 1));
        w_mem_ack   = 1'($urandom_range(0, 1));
        w_mem_rdata = $urandom;
        @(negedge w_clk);
        w_miss_req = 1'b0;
        w_mem_ack  = 1'b0;
        // idle gap with stray acks
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            w_mem_ack   = 1'($urandom_range(0, 1));
            w_mem_rdata = $urandom;
            @(negedge w_clk);
        end
        w_mem_ack = 1'b0;
    endtask

    task automatic reset_in_req();
        @(negedge w_clk);
        w_miss_req = 1'b1;
        w_miss_adr = $urandom;
        exp_adr    = {w_miss_adr[31:2], 2'b00};
        @(negedge w_clk);
        w_miss_req = 1'b0;
        repeat (3) @(negedge w_clk);
        w_rst_n = 1'b0;
        @(negedge w_clk);
        w_rst_n     = 1'b1;
        model_cnt   = '0;
        w_mem_ack   = 1'b1;
        w_mem_rdata = $urandom;
        @(negedge w_clk);
        w_mem_ack = 1'b0;
        repeat (3) @(negedge w_clk);
    endtask

    task automatic wrap_cnt();
        @(negedge w_clk);
        force dut.r_fill_cnt = 32'hFFFF_FFFF;
        @(negedge w_clk);
        release dut.r_fill_cnt;
        model_cnt = 32'hFFFF_FFFF;
        run_txn($urandom, int'($urandom_range(0, 3)), $urandom);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge w_clk) begin
        exp_t e;
        #1;
        if (!w_rst_n) begin
            chk("reset_ctl", {59'd0, w_busy, w_mem_req, w_we, w_done, w_err}, 64'd0);
            chk("reset_mem_adr", {32'd0, w_mem_adr}, 64'd0);
            chk("reset_wd", {6'd0, w_wd}, 64'd0);
            chk("reset_fill_cnt", {32'd0, w_fill_cnt}, 64'd0);
            req_run = 0;
        end else begin
            chk("busy", {63'd0, w_busy}, {63'd0, (w_mem_req | w_we | w_err)});
            chk("done_vs_we", {63'd0, w_done}, {63'd0, w_we});
            if (!w_we) chk("wd_wadr_idle", {1'b0, w_wadr, w_wd}, 64'd0);
            if (w_mem_req) begin
                req_run++;
                chk("mem_adr", {32'd0, w_mem_adr}, {32'd0, exp_adr});
            end
            if (w_we || w_err) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got we=%0b err=%0b expected none", w_we, w_err);
                end else begin
                    e = sb.pop_front();
                    chk("err_pulse", {63'd0, w_err}, {63'd0, e.is_err});
                    chk("we_pulse", {63'd0, w_we}, {63'd0, !e.is_err});
                    chk("req_cycles", 64'(req_run), 64'(e.req_cyc));
                    chk("wadr", {59'd0, w_wadr}, {59'd0, e.wadr});
                    chk("wd", {6'd0, w_wd}, {6'd0, e.wd});
                    chk("fill_cnt", {32'd0, w_fill_cnt}, {32'd0, e.cnt});
                end
                req_run = 0;
            end
        end
    end

    initial begin
        int r;
        int d;
        repeat (3) @(negedge w_clk);
        w_rst_n = 1'b1;
        run_txn(32'h0000_1234, 0, 32'hDEAD_BEEF);
        run_txn($urandom, 10, $urandom);
        run_txn($urandom, TO - 1, $urandom);
        run_txn($urandom, TO, $urandom);
        run_txn($urandom, TO + 5, $urandom);
        reset_in_req();
        run_txn($urandom, 2, $urandom);
        wrap_cnt();
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)       d = 0;
            else if (r == 3) d = TO - 1;
            else if (r == 4) d = TO;
            else             d = int'($urandom_range(1, TO - 2));
            run_txn($urandom, d, $urandom);
        end
        repeat (4) @(negedge w_clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
